// File: rtl/apb4_ram_slave_param.sv
// Parametrised APB4 completer in front of a word-addressed on-chip RAM with byte strobes,
// range/protocol error reporting and optional PPROT secure-region checks (APB_PROT_CHECK_EN).
module apb4_ram_slave_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int WAIT_STATES  = 0,
    parameter int SECURE_BASE  = 0,
    parameter int SECURE_WORDS = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int MEM_AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    typedef struct packed {
        logic instr;
        logic nonsecure;
        logic priv;
    } pprot_t;

    apb_state_t              r_state;
    apb_state_t              w_next;
    logic [3:0]              r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_ready;
    logic                    w_err;
    logic                    w_err_range;
    logic                    w_err_strb;
    logic                    w_err_prot;
    logic                    w_wr_en;
    logic [MEM_AW-1:0]       w_mem_idx;
    logic                    w_unused;

    // Handshake: PREADY is high for exactly one cycle at the end of ACCESS while PSEL is held;
    // PSLVERR and PRDATA carry meaning only in that cycle and are forced to zero otherwise.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == SETUP) begin
                r_cnt <= 4'(WAIT_STATES);
            end else if (r_state == ACCESS && PSEL && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (r_state == SETUP) begin
            r_idx   <= PADDR[ADDR_WIDTH-1:LSB];
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) w_next = SETUP;
            end
            SETUP: begin
                w_next = ACCESS;
            end
            ACCESS: begin
                if (!PSEL) begin
                    w_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_ready = 1'b1;
                    w_next  = PENABLE ? IDLE : SETUP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_err_range = ({1'b0, r_idx} >= (IDX_W+1)'(DEPTH));
    assign w_err_strb  = !r_write && (r_strb != '0);

`ifdef APB_PROT_CHECK_EN
    localparam logic [IDX_W:0] SEC_LO = (IDX_W+1)'(SECURE_BASE);
    localparam logic [IDX_W:0] SEC_HI = (IDX_W+1)'(SECURE_BASE + SECURE_WORDS);
    pprot_t r_prot;

    always_ff @(posedge PCLK) begin
        if (r_state == SETUP) r_prot <= PPROT;
    end

    // Instruction writes are refused everywhere; non-secure accesses only inside the window.
    assign w_err_prot = (r_prot.nonsecure && ({1'b0, r_idx} >= SEC_LO) && ({1'b0, r_idx} < SEC_HI))
                      || (r_write && r_prot.instr);
`else
    localparam int unused_sec = SECURE_BASE + SECURE_WORDS;
    assign w_err_prot = 1'b0;
`endif

    assign w_err     = w_err_range || w_err_strb || w_err_prot;
    assign w_mem_idx = r_idx[MEM_AW-1:0];
    assign w_wr_en   = w_ready && r_write && !w_err;
    assign w_unused  = ^{PADDR, PPROT};

    always_ff @(posedge PCLK) begin
        if (!PRESET && w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (r_strb[b]) r_mem[w_mem_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
        end
    end

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && w_err;
    assign PRDATA  = (w_ready && !r_write && !w_err) ? r_mem[w_mem_idx] : '0;

endmodule

// File: tb/tb_apb4_ram_slave_param.sv
// Directed bench for apb4_ram_slave_param: one zero-wait and one three-wait instance on a shared bus,
// table of transfers plus hand sequences for back-to-back, abort and reset-in-flight cases.
module tb_apb4_ram_slave_param;
    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        sel;
    logic        psel0, psel1;
    logic [31:0] prdata0, prdata1, prdata;
    logic        pready0, pready1, pready;
    logic        pslverr0, pslverr1, pslverr;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    assign psel0   = psel & ~sel;
    assign psel1   = psel & sel;
    assign prdata  = sel ? prdata1 : prdata0;
    assign pready  = sel ? pready1 : pready0;
    assign pslverr = sel ? pslverr1 : pslverr0;

    apb4_ram_slave_param #(.WAIT_STATES(0)) u_dut0 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb4_ram_slave_param #(.WAIT_STATES(3)) u_dut1 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [31:0] a, input logic w,
                                input logic [31:0] d, input logic [3:0] st, input logic [2:0] pr,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.sel = s; v.addr = a; v.wr = w; v.wdata = d; v.strb = st; v.prot = pr;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0; pwdata = 32'h0; pprot = 3'b000;
    endtask

    task automatic apb_xfer(input vec_t v, output logic [31:0] rdata, output logic err,
                            output int lows, output logic after, output logic leak);
        @(posedge pclk); #1;
        sel = v.sel; psel = 1'b1; penable = 1'b0; paddr = v.addr; pwrite = v.wr;
        pwdata = v.wdata; pstrb = v.strb; pprot = v.prot;
        @(posedge pclk); #1;
        penable = 1'b1;
        lows = 0; leak = 1'b0;
        forever begin
            @(negedge pclk);
            if (pready === 1'b1) break;
            if (prdata !== 32'h0 || pslverr !== 1'b0) leak = 1'b1;
            lows++;
            if (lows > 40) break;
        end
        rdata = prdata;
        err   = pslverr;
        @(posedge pclk); #1;
        bus_idle();
        @(negedge pclk);
        after = pready;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [31:0] rdata;
        logic        err, after, leak;
        int          lows;
        apb_xfer(v, rdata, err, lows, after, leak);
        check($sformatf("v%0d prdata", i), rdata, v.exp_rdata);
        check($sformatf("v%0d pslverr", i), {31'b0, err}, {31'b0, v.exp_err});
        check($sformatf("v%0d latency", i), 32'(lows), v.sel ? 32'd4 : 32'd1);
        check($sformatf("v%0d single_ready", i), {31'b0, after}, 32'd0);
        check($sformatf("v%0d zero_when_not_ready", i), {31'b0, leak}, 32'd0);
    endtask

    initial begin
        vecs.push_back(mk(1'b0, 32'h10,  1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  1'b0, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 32'h20,  1'b1, 32'h11223344, 4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h20,  1'b1, 32'hAABBCCDD, 4'h5, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h20,  1'b0, 32'h0,        4'h0, 3'b000, 32'h11BB33DD, 1'b0));
        vecs.push_back(mk(1'b0, 32'h23,  1'b0, 32'h0,        4'h0, 3'b000, 32'h11BB33DD, 1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  1'b1, 32'h77000000, 4'h8, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  1'b0, 32'h0,        4'h0, 3'b000, 32'h77ADBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h400, 1'b0, 32'h0,        4'h0, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h08,  1'b0, 32'h0,        4'h1, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h400, 1'b1, 32'h12345678, 4'hF, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,        4'h0, 3'b000, 32'hCAFEF00D, 1'b0));
        vecs.push_back(mk(1'b0, 32'h20,  1'b1, 32'hFFFFFFFF, 4'h0, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h20,  1'b0, 32'h0,        4'h0, 3'b000, 32'h11BB33DD, 1'b0));
        vecs.push_back(mk(1'b0, 32'h3FC, 1'b1, 32'h0BADCAFE, 4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h3FC, 1'b0, 32'h0,        4'h0, 3'b000, 32'h0BADCAFE, 1'b0));
        vecs.push_back(mk(1'b0, 32'h80000010, 1'b0, 32'h0,   4'h0, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h04,  1'b1, 32'h5A5AA5A5, 4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h04,  1'b0, 32'h0,        4'h0, 3'b000, 32'h5A5AA5A5, 1'b0));
        vecs.push_back(mk(1'b1, 32'h30,  1'b1, 32'h01020304, 4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h30,  1'b0, 32'h0,        4'h0, 3'b000, 32'h01020304, 1'b0));
`ifdef APB_PROT_CHECK_EN
        vecs.push_back(mk(1'b0, 32'h0,   1'b1, 32'h5,        4'hF, 3'b010, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,        4'h0, 3'b000, 32'hCAFEF00D, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   1'b1, 32'h5,        4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,        4'h0, 3'b000, 32'h5,        1'b0));
        vecs.push_back(mk(1'b0, 32'h100, 1'b1, 32'h9,        4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h100, 1'b1, 32'hA,        4'hF, 3'b100, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h100, 1'b0, 32'h0,        4'h0, 3'b010, 32'h9,        1'b0));
        vecs.push_back(mk(1'b0, 32'h3C,  1'b0, 32'h0,        4'h0, 3'b010, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h40,  1'b1, 32'h40,       4'hF, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h40,  1'b0, 32'h0,        4'h0, 3'b010, 32'h40,       1'b0));
`else
        vecs.push_back(mk(1'b0, 32'h0,   1'b1, 32'h5,        4'hF, 3'b010, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,        4'h0, 3'b010, 32'h5,        1'b0));
        vecs.push_back(mk(1'b0, 32'h100, 1'b1, 32'hA,        4'hF, 3'b100, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h100, 1'b0, 32'h0,        4'h0, 3'b110, 32'hA,        1'b0));
`endif

        // Reset held while a setup phase is on the bus: both slaves stay quiet.
        sel = 1'b0; paddr = 32'h0; bus_idle();
        preset = 1'b1; psel = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset pready0", {31'b0, pready0}, 32'd0);
        check("reset pready1", {31'b0, pready1}, 32'd0);
        check("reset pslverr", {31'b0, pslverr0 | pslverr1}, 32'd0);
        check("reset prdata", prdata0 | prdata1, 32'h0);
        @(posedge pclk); #1;
        preset = 1'b0; bus_idle();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back: next setup phase presented during the write's PREADY cycle.
        @(posedge pclk); #1;
        sel = 1'b0; psel = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1;
        pwdata = 32'h13572468; pstrb = 4'hF; pprot = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("b2b wr setup pready", {31'b0, pready}, 32'd0);
        @(posedge pclk); #1;
        penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0; pwdata = 32'h0;
        @(negedge pclk);
        check("b2b wr pready", {31'b0, pready}, 32'd1);
        check("b2b wr pslverr", {31'b0, pslverr}, 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("b2b rd setup pready", {31'b0, pready}, 32'd0);
        @(posedge pclk); #1;
        @(negedge pclk);
        check("b2b rd pready", {31'b0, pready}, 32'd1);
        check("b2b rd prdata", prdata, 32'h13572468);
        @(posedge pclk); #1;
        bus_idle();

        // Abort: PSEL drops mid-ACCESS on the waited slave; the write must not land.
        @(posedge pclk); #1;
        sel = 1'b1; psel = 1'b1; penable = 1'b0; paddr = 32'h04; pwrite = 1'b1;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        bus_idle();
        begin
            logic seen_ready;
            seen_ready = 1'b0;
            repeat (6) begin
                @(negedge pclk);
                if (pready1 !== 1'b0) seen_ready = 1'b1;
            end
            check("abort no pready", {31'b0, seen_ready}, 32'd0);
        end
        run_vec(100, mk(1'b1, 32'h04, 1'b0, 32'h0, 4'h0, 3'b000, 32'h5A5AA5A5, 1'b0));

        // Reset lands in the PREADY cycle of a write: the write must be dropped.
        @(posedge pclk); #1;
        sel = 1'b1; psel = 1'b1; penable = 1'b0; paddr = 32'h30; pwrite = 1'b1;
        pwdata = 32'hFFFF0000; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (4) @(posedge pclk);
        #1;
        preset = 1'b1;
        @(negedge pclk);
        check("rst ready cycle pready", {31'b0, pready}, 32'd1);
        @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        check("post rst pready", {31'b0, pready}, 32'd0);
        check("post rst pslverr", {31'b0, pslverr}, 32'd0);
        check("post rst prdata", prdata, 32'h0);
        @(posedge pclk); #1;
        @(negedge pclk);
        check("penable in idle ignored", {31'b0, pready}, 32'd0);
        @(posedge pclk); #1;
        bus_idle();
        run_vec(101, mk(1'b1, 32'h30, 1'b0, 32'h0, 4'h0, 3'b000, 32'h01020304, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
